// File: rtl/voice_gen.sv
// rtl/voice_gen.sv - sawtooth synth voice with ADSR envelope
// Slow-domain note_rst/key are resynchronised; START clears phase, END releases.
module voice_gen #(
  parameter int PHASE_W   = 24,
  parameter int SAMPLE_HZ = 48828,
  parameter int ATK_STEP  = 8,
  parameter int DEC_STEP  = 1,
  parameter int SUS_LVL   = 160,
  parameter int REL_STEP  = 4
) (
  input  logic               clk,
  input  logic               grst,
  input  logic               sample_en,
  input  logic               env_en,
  input  logic               note_rst,
  input  logic [6:0]         key,
  output logic signed [15:0] sample,
  output logic               sample_valid,
  output logic [7:0]         env,
  output logic               active
);

  typedef enum logic [2:0] {ST_IDLE, ST_ATTACK, ST_DECAY, ST_SUSTAIN, ST_RELEASE} state_t;

  // Top-octave (octave 10) increment for each semitone; lower octaves shift right.
  function automatic logic [PHASE_W-1:0] base_inc(input int s);
    real f;
    f = 440.0 * (2.0 ** ($itor(120 + s - 69) / 12.0)) * (2.0 ** $itor(PHASE_W)) / $itor(SAMPLE_HZ);
    return PHASE_W'($rtoi(f + 0.5));
  endfunction

  localparam logic [PHASE_W-1:0] BASE [12] = '{
    base_inc(0), base_inc(1), base_inc(2), base_inc(3), base_inc(4),  base_inc(5),
    base_inc(6), base_inc(7), base_inc(8), base_inc(9), base_inc(10), base_inc(11)
  };

  logic               nr_q1, nr_s, nr_d;
  logic [6:0]         key_q1, key_s, key_lat;
  logic               start, note_end, gate_on, end_hit, decay_skip, env_step;
  logic [3:0]         semi, oct;
  logic [PHASE_W-1:0] inc, phase, phase_nxt;
  logic signed [7:0]  saw;
  logic signed [15:0] prod;
  state_t             state, state_nxt;
  logic [7:0]         env_nxt;

  always_ff @(posedge clk or posedge grst) begin
    if (grst) begin
      nr_q1  <= 1'b0;
      nr_s   <= 1'b0;
      nr_d   <= 1'b0;
      key_q1 <= '0;
      key_s  <= '0;
    end else begin
      nr_q1  <= note_rst;
      nr_s   <= nr_q1;
      nr_d   <= nr_s;
      key_q1 <= key;
      key_s  <= key_q1;
    end
  end

  assign start      = nr_d & ~nr_s;
  assign note_end   = nr_s & ~nr_d;
  assign gate_on    = (state == ST_ATTACK) || (state == ST_DECAY) || (state == ST_SUSTAIN);
  assign end_hit    = note_end & gate_on;
  assign decay_skip = (state == ST_DECAY) && (SUS_LVL >= 255);
  assign env_step   = env_en & ~start & ~end_hit & ~decay_skip;

  always_comb begin
    semi = 4'(key_lat % 7'd12);
    oct  = 4'(key_lat / 7'd12);
    inc  = (key_lat == '0) ? '0 : (BASE[semi] >> (4'd10 - oct));
  end

  // A START in the same cycle as sample_en wins: the phase restarts at zero.
  always_comb begin
    phase_nxt = phase;
    if (start)
      phase_nxt = '0;
    else if (sample_en)
      phase_nxt = phase + inc;
    saw  = phase_nxt[PHASE_W-1 -: 8];
    prod = 16'(saw) * 16'($signed({1'b0, env}));
  end

  always_ff @(posedge clk or posedge grst) begin
    if (grst) begin
      phase        <= '0;
      key_lat      <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      phase        <= phase_nxt;
      sample_valid <= sample_en;
      if (sample_en)
        sample <= prod;
      if (start)
        key_lat <= key_s;
    end
  end

  always_ff @(posedge clk or posedge grst) begin
    if (grst) begin
      state <= ST_IDLE;
      env   <= '0;
    end else begin
      state <= state_nxt;
      env   <= env_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (start)
      state_nxt = (key_s != '0) ? ST_ATTACK : ST_RELEASE;
    else if (end_hit)
      state_nxt = ST_RELEASE;
    else if (decay_skip)
      state_nxt = ST_SUSTAIN;
    else if (env_en) begin
      case (state)
        ST_ATTACK:  if (int'(env) + ATK_STEP >= 255)     state_nxt = ST_DECAY;
        ST_DECAY:   if (int'(env) - DEC_STEP <= SUS_LVL) state_nxt = ST_SUSTAIN;
        ST_RELEASE: if (int'(env) <= REL_STEP)           state_nxt = ST_IDLE;
        default:    state_nxt = state;
      endcase
    end
  end

  // Retrigger keeps env as-is so legato notes continue from the current level.
  always_comb begin
    env_nxt = env;
    active  = (state != ST_IDLE);
    if (env_step) begin
      case (state)
        ST_IDLE:    env_nxt = '0;
        ST_ATTACK:  env_nxt = (int'(env) + ATK_STEP >= 255) ? 8'd255 : env + 8'(ATK_STEP);
        ST_DECAY:   env_nxt = (int'(env) - DEC_STEP <= SUS_LVL) ? 8'(SUS_LVL) : env - 8'(DEC_STEP);
        ST_RELEASE: env_nxt = (int'(env) <= REL_STEP) ? 8'd0 : env - 8'(REL_STEP);
        default:    env_nxt = env;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_gen.sv
// tb/tb_voice_gen.sv - directed bench for voice_gen
// Vector table for pitch increments plus hand-written envelope/sample sequences.
module tb_voice_gen;

  logic               clk = 1'b0;
  logic               grst, sample_en, env_en, note_rst;
  logic [6:0]         key;
  logic signed [15:0] sample;
  logic               sample_valid;
  logic [7:0]         env;
  logic               active;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [6:0] key;
    int         exp_inc;
  } inc_vec_t;

  inc_vec_t vecs [8];

  voice_gen dut (
    .clk(clk), .grst(grst), .sample_en(sample_en), .env_en(env_en),
    .note_rst(note_rst), .key(key), .sample(sample), .sample_valid(sample_valid),
    .env(env), .active(active)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    grst = 1'b1; note_rst = 1'b1; key = '0; sample_en = 1'b0; env_en = 1'b0;
    tick();
    grst = 1'b0;
    tick();
  endtask

  task automatic env_steps(input int n);
    env_en = 1'b1;
    repeat (n) tick();
    env_en = 1'b0;
  endtask

  task automatic pulse_sample();
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
  endtask

  // START lands in the cycle after the 2-FF synchroniser; state changes on the 3rd edge.
  task automatic note_on(input logic [6:0] k, input bit chk_lat);
    key = k;
    note_rst = 1'b1;
    repeat (4) tick();
    note_rst = 1'b0;
    tick();
    tick();
    if (chk_lat) check("pre_start_active", longint'(active), 0);
    tick();
    check("start_active", longint'(active), 1);
  endtask

  initial begin
    longint ph;
    int     top;

    vecs[0] = '{7'd69,  151183};
    vecs[1] = '{7'd81,  302366};
    vecs[2] = '{7'd57,  75591};
    vecs[3] = '{7'd0,   0};
    vecs[4] = '{7'd9,   4724};
    vecs[5] = '{7'd105, 1209466};
    vecs[6] = '{7'd117, 2418932};
    vecs[7] = '{7'd127, 4310046};

    grst = 1'b1; note_rst = 1'b1; key = '0; sample_en = 1'b0; env_en = 1'b0;
    tick();
    check("rst_sample", longint'(sample), 0);
    check("rst_valid", longint'(sample_valid), 0);
    check("rst_env", longint'(env), 0);
    check("rst_active", longint'(active), 0);

    for (int i = 0; i < 8; i++) begin
      do_reset();
      note_on(vecs[i].key, 1'b1);
      check($sformatf("inc_key%0d", vecs[i].key), longint'(dut.inc), longint'(vecs[i].exp_inc));
    end

    // Attack to the peak, then walk the phase across 2053 samples at env=255.
    do_reset();
    note_on(7'd69, 1'b1);
    check("attack_env0", longint'(env), 0);
    env_steps(31);
    check("attack_env248", longint'(env), 248);
    env_steps(1);
    check("attack_env255", longint'(env), 255);
    ph = 0;
    for (int n = 1; n <= 2053; n++) begin
      pulse_sample();
      ph  = (ph + 151183) % 16777216;
      top = int'(ph >> 16);
      if (top >= 128) top -= 256;
      check("saw_sample", longint'(sample), longint'(top * 255));
      check("valid_on", longint'(sample_valid), 1);
      tick();
      check("valid_off", longint'(sample_valid), 0);
    end
    check("saw_min", longint'(sample), -32640);
    env_steps(95);
    check("decay_env160", longint'(env), 160);
    env_steps(3);
    check("sustain_hold", longint'(env), 160);

    note_rst = 1'b1;
    repeat (3) tick();
    check("release_active", longint'(active), 1);
    env_steps(39);
    check("release_env4", longint'(env), 4);
    check("release_active4", longint'(active), 1);
    env_steps(1);
    check("release_env0", longint'(env), 0);
    check("release_idle", longint'(active), 0);

    // Reset mid-sustain takes effect without waiting for a clock edge.
    do_reset();
    note_on(7'd60, 1'b0);
    env_steps(127);
    check("t1_env160", longint'(env), 160);
    pulse_sample();
    check("t1_valid", longint'(sample_valid), 1);
    grst = 1'b1; note_rst = 1'b1;
    #1;
    check("t1_sample", longint'(sample), 0);
    check("t1_valid0", longint'(sample_valid), 0);
    check("t1_env", longint'(env), 0);
    check("t1_active", longint'(active), 0);
    tick();
    grst = 1'b0;
    tick();
    note_on(7'd69, 1'b1);
    check("t1_restart_inc", longint'(dut.inc), 151183);

    // Collisions: START with sample_en and env_en, then a rest-key START.
    do_reset();
    note_on(7'd69, 1'b0);
    env_steps(10);
    check("t6_env80", longint'(env), 80);
    repeat (5) pulse_sample();
    note_rst = 1'b1;
    repeat (4) tick();
    check("t6_rel_env", longint'(env), 80);
    note_rst = 1'b0;
    tick();
    tick();
    sample_en = 1'b1; env_en = 1'b1;
    tick();
    sample_en = 1'b0; env_en = 1'b0;
    check("t6_clr_valid", longint'(sample_valid), 1);
    check("t6_clr_sample", longint'(sample), 0);
    check("t6_env_hold", longint'(env), 80);
    check("t6_active", longint'(active), 1);
    pulse_sample();
    check("t6_first_sample", longint'(sample), 160);
    env_steps(1);
    check("t6_attack_step", longint'(env), 88);

    note_rst = 1'b1; key = 7'd0;
    repeat (4) tick();
    note_rst = 1'b0;
    repeat (3) tick();
    check("rest_active", longint'(active), 1);
    check("rest_inc", longint'(dut.inc), 0);
    pulse_sample();
    check("rest_sample", longint'(sample), 0);
    env_steps(21);
    check("rest_env4", longint'(env), 4);
    check("rest_active4", longint'(active), 1);
    env_steps(1);
    check("rest_env0", longint'(env), 0);
    check("rest_idle", longint'(active), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
